// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-fetch
// requester and a data requester, with a per-access timeout.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_owner_d;
  logic              r_last_d;
  logic              r_busy;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_i_ack;
  logic              r_i_err;
  logic [DATA_W-1:0] r_i_rdata;
  logic              r_d_ack;
  logic              r_d_err;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_any_req;
  logic w_gnt_d;
  logic w_timeout;
  logic w_finish;

  // Data wins only when fetch is idle or fetch was served last.
  assign w_any_req = i_req | d_req;
  assign w_gnt_d   = d_req & (~i_req | ~r_last_d);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_finish  = mem_ready | w_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner_d   <= 1'b0;
      r_last_d    <= 1'b1;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_ack     <= 1'b0;
      r_i_err     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_ack     <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      // NOTE: ack/err default low here so every path out of ACCESS yields a single-cycle pulse.
      r_i_ack <= 1'b0;
      r_i_err <= 1'b0;
      r_d_ack <= 1'b0;
      r_d_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_d   <= w_gnt_d;
            r_mem_we    <= w_gnt_d & d_we;
            r_mem_addr  <= w_gnt_d ? d_addr : i_addr;
            r_mem_wdata <= w_gnt_d ? d_wdata : '0;
            r_mem_req   <= 1'b1;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (w_finish) begin
            r_mem_req <= 1'b0;
            r_last_d  <= r_owner_d;
            r_state   <= S_RESP;
            if (r_owner_d) begin
              r_d_ack <= 1'b1;
              r_d_err <= ~mem_ready;
              if (!r_mem_we) r_d_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              r_i_ack   <= 1'b1;
              r_i_err   <= ~mem_ready;
              r_i_rdata <= mem_ready ? mem_rdata : '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_ack     = r_i_ack;
  assign i_err     = r_i_err;
  assign i_rdata   = r_i_rdata;
  assign d_ack     = r_d_ack;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: table of transactions plus a few
// hand-written reset / protocol corner sequences.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic        i_err;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_ird = '0;
  logic [31:0] exp_drd = '0;

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          waits;   // ACCESS cycles before mem_ready; >= TMO means never
    logic        exp_d;   // 1 = data requester expected to be granted
  } vec_t;

  vec_t vt[11];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, simulation still running (required: finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_req"},   {31'd0, mem_req},   32'd0);
    check({tag, " mem_we"},    {31'd0, mem_we},    32'd0);
    check({tag, " mem_addr"},  mem_addr,           32'd0);
    check({tag, " mem_wdata"}, mem_wdata,          32'd0);
    check({tag, " i_ack"},     {31'd0, i_ack},     32'd0);
    check({tag, " d_ack"},     {31'd0, d_ack},     32'd0);
    check({tag, " i_err"},     {31'd0, i_err},     32'd0);
    check({tag, " d_err"},     {31'd0, d_err},     32'd0);
    check({tag, " i_rdata"},   i_rdata,            32'd0);
    check({tag, " d_rdata"},   d_rdata,            32'd0);
    check({tag, " busy"},      {31'd0, busy},      32'd0);
  endtask

  // Entered in an IDLE cycle (cycle 0); leaves in the IDLE cycle after RESP.
  task automatic apply(input int idx, input vec_t v);
    logic [31:0] exp_addr;
    logic        exp_we;
    logic        exp_err;
    bit          done;
    i_req     = v.ireq;
    d_req     = v.dreq;
    d_we      = v.dwe;
    i_addr    = v.iaddr;
    d_addr    = v.daddr;
    d_wdata   = v.wdata;
    mem_rdata = v.mrdata;
    mem_ready = 1'b0;
    exp_addr  = v.exp_d ? v.daddr : v.iaddr;
    exp_we    = v.exp_d & v.dwe;
    exp_err   = (v.waits >= TMO);
    tick();
    check($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, exp_we});
    if (v.exp_d) check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
    done = 1'b0;
    for (int c = 0; c < TMO && !done; c++) begin
      check($sformatf("v%0d mem_req c%0d", idx, c + 1), {31'd0, mem_req}, 32'd1);
      check($sformatf("v%0d mem_addr c%0d", idx, c + 1), mem_addr, exp_addr);
      check($sformatf("v%0d busy c%0d", idx, c + 1), {31'd0, busy}, 32'd1);
      check($sformatf("v%0d early ack c%0d", idx, c + 1), {30'd0, i_ack, d_ack}, 32'd0);
      mem_ready = (c == v.waits);
      if (mem_ready || c == TMO - 1) done = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    if (!v.exp_d) exp_ird = exp_err ? 32'd0 : v.mrdata;
    else if (!v.dwe) exp_drd = exp_err ? 32'd0 : v.mrdata;
    check($sformatf("v%0d resp mem_req", idx), {31'd0, mem_req}, 32'd0);
    check($sformatf("v%0d resp busy", idx), {31'd0, busy}, 32'd1);
    check($sformatf("v%0d i_ack", idx), {31'd0, i_ack}, {31'd0, ~v.exp_d});
    check($sformatf("v%0d d_ack", idx), {31'd0, d_ack}, {31'd0, v.exp_d});
    check($sformatf("v%0d i_err", idx), {31'd0, i_err}, {31'd0, ~v.exp_d & exp_err});
    check($sformatf("v%0d d_err", idx), {31'd0, d_err}, {31'd0, v.exp_d & exp_err});
    check($sformatf("v%0d i_rdata", idx), i_rdata, exp_ird);
    check($sformatf("v%0d d_rdata", idx), d_rdata, exp_drd);
    if (v.exp_d) d_req = 1'b0;
    else         i_req = 1'b0;
    tick();
    check($sformatf("v%0d idle acks", idx), {28'd0, i_ack, d_ack, i_err, d_err}, 32'd0);
    check($sformatf("v%0d idle busy", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    //         ireq dreq we  iaddr          daddr          wdata          mrdata         waits exp_d
    vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0040_0000, 32'h0,         32'h0,         32'h0050_0093, 0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h1001_0000, 32'hDEAD_BEEF, 32'hBAD0_BAD0, 3, 1'b1};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 32'h0040_0004, 32'h1001_0004, 32'h0,         32'h1111_1111, 1, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 32'h0040_0004, 32'h1001_0004, 32'h0,         32'h2222_2222, 0, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 32'h0040_0008, 32'h0,         32'h0,         32'h3333_3333, 2, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h0040_000C, 32'h1001_0008, 32'h0,         32'h4444_4444, 0, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0040_000C, 32'h0,         32'h0,         32'h5555_5555, 0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h1001_000C, 32'h0,         32'h9999_9999, 9, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 32'h0040_0010, 32'h0,         32'h0,         32'h9999_9999, 9, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h1001_0010, 32'h0,         32'h6666_6666, 0, 1'b1};
    vt[10] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h1001_0014, 32'hCAFE_F00D, 32'h9999_9999, 9, 1'b1};

    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();

    for (int k = 0; k < 11; k++) apply(k, vt[k]);

    // mem_ready outside ACCESS must not start or complete anything
    mem_ready = 1'b1;
    tick();
    tick();
    check("stray ready busy", {31'd0, busy}, 32'd0);
    check("stray ready acks", {30'd0, i_ack, d_ack}, 32'd0);
    check("stray ready mem_req", {31'd0, mem_req}, 32'd0);
    mem_ready = 1'b0;

    // requester drops d_req mid-ACCESS: access still completes with an ack
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0020; mem_rdata = 32'h7777_7777;
    tick();
    d_req = 1'b0;
    tick();
    check("drop mem_req held", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    exp_drd = 32'h7777_7777;
    check("drop d_ack", {31'd0, d_ack}, 32'd1);
    check("drop d_rdata", d_rdata, exp_drd);
    tick();
    check("drop idle busy", {31'd0, busy}, 32'd0);

    // asynchronous reset in cycle 2 of an access abandons it without ack
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0040_0100; d_addr = 32'h1001_0100;
    tick();
    tick();
    check("pre-reset mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("mid reset");
    i_req = 1'b0; d_req = 1'b0;
    exp_ird = '0; exp_drd = '0;
    tick();
    tick();
    check("post reset no ack", {30'd0, i_ack, d_ack}, 32'd0);
    rst = 1'b1;
    tick();
    apply(20, '{1'b1, 1'b1, 1'b0, 32'h0040_0200, 32'h1001_0200, 32'h0, 32'hAAAA_0001, 1, 1'b0});
    apply(21, '{1'b0, 1'b1, 1'b0, 32'h0040_0200, 32'h1001_0200, 32'h0, 32'hAAAA_0002, 0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the processor's instruction-fetch requester and its data (load/store) requester. It sits between the multicycle core's fetch/memory stages and the memory model. Each requester uses a request/acknowledge handshake. The arbiter serialises accesses with round-robin priority, waits a variable number of cycles for memory readiness, and reports a timeout error if memory never responds.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum ACCESS cycles without mem_ready before abort; must be ≥1
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch address, stable while i_req=1
- i_ack  out  1  one-cycle completion pulse for fetch
- i_err  out  1  valid with i_ack; 1 = timed out
- i_rdata  out  DATA_W  fetched word, valid from i_ack onward
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req=1
- d_addr  in  ADDR_W  data address, stable while d_req=1
- d_wdata  in  DATA_W  store data, stable while d_req=1
- d_ack  out  1  one-cycle completion pulse for data
- d_err  out  1  valid with d_ack; 1 = timed out
- d_rdata  out  DATA_W  load word, valid from d_ack onward
- mem_req  out  1  memory access active
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1
- mem_ready  in  1  memory completes the access this cycle
- busy  out  1  high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- **IDLE**
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester other than last_gnt.
  - On grant: latch we/addr/wdata into the mem_* registers (mem_we=0 for fetch), set mem_req=1, clear the timeout counter, record the owner, go to ACCESS.
- **ACCESS**
  - mem_* outputs stay constant.
  - When mem_ready=1:
    - Deassert mem_req.
    - For a read, latch mem_rdata into the owner's rdata.
    - Set the owner's ack=1 and err=0, update last_gnt to the owner, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with mem_ready=0:
    - Deassert mem_req.
    - Set the owner's rdata=0 for a read; a store leaves d_rdata unchanged.
    - Set ack=1 and err=1, update last_gnt, go to RESP.
  - mem_ready on the final counted cycle wins over timeout.
- **RESP**
  - ack and err are high for exactly this cycle. Next state is IDLE; ack and err clear.
  - req inputs are ignored in RESP.
  - A req still high in the following IDLE cycle is a new request.
- Stores never modify d_rdata. Fetches never modify d_*, and data accesses never modify i_*.
- If a requester drops req during ACCESS (protocol violation), the access still completes and ack still pulses.
- Counter width: $clog2(TIMEOUT+1); it never wraps.
- mem_ready outside ACCESS is ignored.

## Timing
- **Reset (rst=0, asynchronous)**
  - State=IDLE; last_gnt=D, so fetch wins the first tie.
  - All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, i_ack, d_ack, i_err, d_err, i_rdata, d_rdata, busy.
  - Reset mid-ACCESS drops mem_req immediately and abandons the transaction with no ack.
- **Latency**
  - req first high in cycle 0 (IDLE) → mem_req high from cycle 1.
  - mem_ready in cycle k≥1 → ack in cycle k+1.
  - Minimum 2 cycles request-to-ack; back-to-back throughput is one access per 3 cycles.
- **Timeout**: mem_req is high for exactly TIMEOUT cycles, then ack/err are high the next cycle.
- busy = (state≠IDLE), registered alongside state.

## Test plan
- **Fetch, zero-wait memory**: after reset, i_req=1, i_addr=0x00400000, mem_ready=1 with mem_rdata=0x00500093 → mem_addr=0x00400000, mem_we=0 in cycle 1; i_ack=1, i_err=0, i_rdata=0x00500093 in cycle 2; d_ack stays 0.
- **Store with 3 wait cycles**: d_req=1, d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF; mem_ready asserted in cycle 4 → mem_we=1, mem_wdata=0xDEADBEEF during cycles 1–4; d_ack in cycle 5; d_rdata unchanged.
- **Round-robin**:
  - Simultaneous i_req/d_req right after reset → fetch served first, then data.
  - Repeat with last_gnt=I → data served first.
  - Each ack pulses exactly once.
- **Timeout**: TIMEOUT=4, d_req load, mem_ready held 0 → mem_req high exactly cycles 1–4; cycle 5 d_ack=1, d_err=1, d_rdata=0; returns to IDLE.
- **Reset mid-ACCESS**: pull rst low in cycle 2 of an access → all outputs 0 asynchronously, no ack. After release, a simultaneous request grants fetch first and completes normally.
